// File: rtl/completion_serializer.sv
// Round-robin completion arbiter that serializes the winning {source_id, addr} MSB first,
// then issues a one-cycle scoreboard clear for the granted source.
module completion_serializer #(
  parameter int NUM_FSM  = 4,
  parameter int ADDR_W   = 10,
  parameter int SRC_ID_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FSM-1:0]           cmpl_valid,
  input  logic [NUM_FSM*ADDR_W-1:0]    cmpl_addr,
  input  logic [NUM_FSM*SRC_ID_W-1:0]  cmpl_source_id,
  output logic [NUM_FSM-1:0]           cmpl_arb_won,
  output logic                         ser_data,
  output logic                         ser_valid,
  input  logic                         ser_ready,
  output logic                         sb_clear_valid,
  output logic [SRC_ID_W-1:0]          sb_clear_source_id
);

  localparam int FRAME_W = SRC_ID_W + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int PTR_W   = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [SRC_ID_W-1:0]  clr_id_q, clr_id_d;

  logic [ADDR_W-1:0]    addr_arr [NUM_FSM];
  logic [SRC_ID_W-1:0]  src_arr  [NUM_FSM];
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     ptr_after_win;
  logic                 any_valid;
  logic [NUM_FSM-1:0]   win_onehot;

  for (genvar gi = 0; gi < NUM_FSM; gi++) begin : g_unpack
    assign addr_arr[gi] = cmpl_addr[gi*ADDR_W +: ADDR_W];
    assign src_arr[gi]  = cmpl_source_id[gi*SRC_ID_W +: SRC_ID_W];
  end

  assign any_valid = |cmpl_valid;

  // Search from rr_ptr upward (wrapping); iterating high-to-low lets the nearest hit win.
  always_comb begin
    int idx;
    win_idx = '0;
    for (int k = NUM_FSM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FSM) idx = idx - NUM_FSM;
      if (cmpl_valid[idx]) win_idx = PTR_W'(idx);
    end
  end

  always_comb begin
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  if (NUM_FSM > 1) begin : g_ptr
    assign ptr_after_win = (win_idx == PTR_W'(NUM_FSM - 1)) ? '0 : win_idx + 1'b1;
  end else begin : g_ptr_single
    assign ptr_after_win = '0;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    clr_id_d     = clr_id_q;
    cmpl_arb_won = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          cmpl_arb_won = rst ? '0 : win_onehot;
          shift_d      = {src_arr[win_idx], addr_arr[win_idx]};
          clr_id_d     = src_arr[win_idx];
          rr_ptr_d     = ptr_after_win;
          bit_cnt_d    = CNT_W'(FRAME_W - 1);
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Without ser_ready the current bit and count are held, so nothing is lost or repeated.
        if (ser_ready) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            state_d = ST_CLEAR;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clr_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clr_id_q  <= clr_id_d;
    end
  end

  assign ser_valid          = (state_q == ST_SHIFT);
  assign ser_data           = (state_q == ST_SHIFT) & shift_q[FRAME_W-1];
  assign sb_clear_valid     = (state_q == ST_CLEAR);
  assign sb_clear_source_id = (state_q == ST_CLEAR) ? clr_id_q : '0;

endmodule

// File: tb/tb_completion_serializer.sv
// Bench for completion_serializer: directed scenarios plus randomized traffic checked against
// a frame-level model of round-robin grants, serial bit order and clear timing.
module tb_completion_serializer;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int SW = 4;
  localparam int FW = AW + SW;

  logic              clk;
  logic              rst;
  logic [N-1:0]      cmpl_valid;
  logic [N*AW-1:0]   cmpl_addr;
  logic [N*SW-1:0]   cmpl_source_id;
  logic [N-1:0]      cmpl_arb_won;
  logic              ser_data;
  logic              ser_valid;
  logic              ser_ready;
  logic              sb_clear_valid;
  logic [SW-1:0]     sb_clear_source_id;

  completion_serializer #(.NUM_FSM(N), .ADDR_W(AW), .SRC_ID_W(SW)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmpl_valid         (cmpl_valid),
    .cmpl_addr          (cmpl_addr),
    .cmpl_source_id     (cmpl_source_id),
    .cmpl_arb_won       (cmpl_arb_won),
    .ser_data           (ser_data),
    .ser_valid          (ser_valid),
    .ser_ready          (ser_ready),
    .sb_clear_valid     (sb_clear_valid),
    .sb_clear_source_id (sb_clear_source_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference state: pending requests, their payloads, and the rotating priority pointer.
  logic [N-1:0]  valid_v;
  logic [SW-1:0] src_a  [N];
  logic [AW-1:0] addr_a [N];
  int            ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cmpl_valid = valid_v;
    for (int i = 0; i < N; i++) begin
      cmpl_addr[i*AW +: AW]      = addr_a[i];
      cmpl_source_id[i*SW +: SW] = src_a[i];
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Called at a negedge with the DUT idle and requests driven. Runs one whole frame.
  task automatic do_frame(input bit drop, input int stall_at, input int stall_len,
                          input bit rnd, output int grant_cyc);
    int w, got, guard, stalled;
    logic [FW-1:0] fr;
    logic [SW-1:0] exp_id;
    logic r;
    w = model_winner(valid_v, ptr);
    if (w < 0) w = 0;
    fr = {src_a[w], addr_a[w]};
    exp_id = src_a[w];
    #1;
    chk("grant", cmpl_arb_won, 32'(1) << w);
    chk("idle_ser_valid", ser_valid, 0);
    grant_cyc = cyc;
    ptr = (w + 1) % N;
    $display("frame fsm=%0d src=%0h addr=%0h frame=%0h", w, src_a[w], addr_a[w], fr);
    @(negedge clk);
    if (drop) begin
      valid_v[w] = 1'b0;
      src_a[w]   = SW'($urandom);
      addr_a[w]  = AW'($urandom);
      if (rnd) begin
        for (int i = 0; i < N; i++) begin
          if (!valid_v[i] && ($urandom_range(0, 2) == 0)) begin
            valid_v[i] = 1'b1;
            src_a[i]   = SW'($urandom);
            addr_a[i]  = AW'($urandom);
          end
        end
      end
      drive();
    end
    got = 0; guard = 0; stalled = 0;
    while (got < FW && guard < 200) begin
      r = 1'b1;
      if (rnd) r = ($urandom_range(0, 3) != 0);
      if (got == stall_at && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end
      ser_ready = r;
      #1;
      chk("ser_valid", ser_valid, 1);
      chk($sformatf("ser_data_bit%0d", FW - 1 - got), ser_data, fr[FW-1-got]);
      chk("shift_no_grant", cmpl_arb_won, 0);
      chk("shift_no_clear", sb_clear_valid, 0);
      @(negedge clk);
      if (r) got++;
      guard++;
    end
    chk("frame_timeout", (guard < 200) ? 1 : 0, 1);
    ser_ready = 1'b1;
    #1;
    chk("clear_valid", sb_clear_valid, 1);
    chk("clear_id", sb_clear_source_id, exp_id);
    chk("clear_ser_valid", ser_valid, 0);
    chk("clear_no_grant", cmpl_arb_won, 0);
    @(negedge clk);
  endtask

  initial begin
    int gc, prev_gc, w;
    rst = 1'b1;
    ser_ready = 1'b1;
    valid_v = '1;
    for (int i = 0; i < N; i++) begin
      src_a[i]  = SW'($urandom);
      addr_a[i] = AW'($urandom);
    end
    drive();
    ptr = 0;

    // Reset held two cycles with all requesters pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_grant", cmpl_arb_won, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_data", ser_data, 0);
      chk("rst_clear", sb_clear_valid, 0);
      chk("rst_clear_id", sb_clear_source_id, 0);
    end
    rst = 1'b0;

    // Round robin with everyone requesting: 0,1,2,3,0 spaced FRAME_W+2 cycles.
    prev_gc = 0;
    for (int f = 0; f < 5; f++) begin
      w = model_winner(valid_v, ptr);
      chk("rr_order", w, f % N);
      do_frame(1'b0, -1, 0, 1'b0, gc);
      if (f > 0) chk("rr_spacing", gc - prev_gc, FW + 2);
      prev_gc = gc;
    end

    // Single frame from FSM2 with src=5, addr=2A3.
    valid_v = 4'b0100;
    src_a[2] = 4'h5;
    addr_a[2] = 10'h2A3;
    drive();
    do_frame(1'b1, -1, 0, 1'b0, gc);

    // Same frame with ser_ready low for 3 cycles after the 4th bit.
    valid_v = 4'b0100;
    src_a[2] = 4'h5;
    addr_a[2] = 10'h2A3;
    drive();
    do_frame(1'b1, 4, 3, 1'b0, gc);

    // Pointer skip: grant FSM0 alone (pointer -> 1), then FSM0 and FSM3 compete.
    valid_v = 4'b0001;
    drive();
    do_frame(1'b1, -1, 0, 1'b0, gc);
    valid_v = 4'b1001;
    drive();
    chk("skip_first", model_winner(valid_v, ptr), 3);
    do_frame(1'b1, -1, 0, 1'b0, gc);
    chk("skip_second", model_winner(valid_v, ptr), 0);
    do_frame(1'b1, -1, 0, 1'b0, gc);

    // Randomized traffic with random backpressure and arrivals.
    for (int f = 0; f < 20; f++) begin
      if (valid_v == '0) begin
        w = $urandom_range(0, N - 1);
        valid_v[w] = 1'b1;
        src_a[w]   = SW'($urandom);
        addr_a[w]  = AW'($urandom);
      end
      drive();
      do_frame(1'b1, -1, 0, 1'b1, gc);
    end

    // Mid-frame reset after 6 bits: frame aborts, no clear, arbitration restarts at FSM0.
    valid_v = 4'b0100;
    drive();
    #1;
    chk("mid_grant", cmpl_arb_won, 4'b0100);
    @(negedge clk);
    valid_v = 4'b1111;
    drive();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("mid_ser_valid", ser_valid, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("mid_rst_ser_valid", ser_valid, 0);
      chk("mid_rst_clear", sb_clear_valid, 0);
      chk("mid_rst_grant", cmpl_arb_won, 0);
    end
    rst = 1'b0;
    ptr = 0;
    do_frame(1'b1, -1, 0, 1'b0, gc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
